// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C register-interface responder.
// No logic; types only.
// No flow control; consumed by i2c_slave_regif and its bench.
package i2c_slave_pkg;

  // Protocol states of the responder
  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    IGNORE,
    ACK,
    SUB,
    WDATA,
    RDATA,
    MACK
  } state_t;

  // Codec default 7-bit target address (0x34 write / 0x35 read on the wire)
  localparam logic [6:0] DEF_SLAVE_ADDR = 7'h1A;

  // Position of the R/W flag inside the address byte
  localparam int RW_BIT = 0;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into CLOCK and emits one-cycle scl_rise/scl_fall/start/stop pulses.
// Latency: events lag the pins by SYNC_STAGES+1 CLOCKs; sda_s is aligned with the events.
// No backpressure; pulses are produced unconditionally every CLOCK.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLOCK,
  input  logic RESET_N,
  input  logic I2C_SCLK,
  input  logic I2C_SDAT,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_c;
  logic                   sda_c;
  logic                   scl_d;

  assign scl_c = scl_sync[SYNC_STAGES-1];
  assign sda_c = sda_sync[SYNC_STAGES-1];

  // Synchronizer chains; reset to the idle-bus level so reset exit makes no false START
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], I2C_SCLK};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], I2C_SDAT};
    end
  end

  // Edge-detect register: previous levels plus registered event pulses
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      scl_d     <= 1'b1;
      sda_s     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_d     <= scl_c;
      sda_s     <= sda_c;
      scl_rise  <= scl_c & ~scl_d;
      scl_fall  <= ~scl_c & scl_d;
      start_det <= scl_c & scl_d & sda_s & ~sda_c;
      stop_det  <= scl_c & scl_d & ~sda_s & sda_c;
    end
  end

endmodule

// File: rtl/i2c_slave_regif.sv
// I2C responder turning [ADDR+W, SUB, DATA...] into WR_EN strobes and serving reads via repeated START.
// Latency: WR_EN one CLOCK after the 8th data bit's SCL rise event (pins + SYNC_STAGES+2 CLOCKs).
// No SCL stretching; the master paces everything, CLOCK must be >=10x SCL.
module i2c_slave_regif
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = DEF_SLAVE_ADDR,
  parameter int          SYNC_STAGES = 2
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  output logic       WR_EN,
  output logic [7:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  output logic [7:0] RD_ADDR,
  input  logic [7:0] RD_DATA,
  output logic       BUSY
);

  logic       scl_rise, scl_fall, start_det, stop_det, sda_s;
  state_t     state, state_nxt, ack_ret;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic [7:0] ptr;
  logic       sda_low, ack_drv, rd_load, sda_oe;
  logic [7:0] rx_byte;
  logic       byte_done, addr_hit;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLOCK     (CLOCK),
    .RESET_N   (RESET_N),
    .I2C_SCLK  (I2C_SCLK),
    .I2C_SDAT  (I2C_SDAT),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  // Byte assembled as if the current rise were the last one shifted in
  assign rx_byte   = {shreg, sda_s};
  assign byte_done = scl_rise && (bit_cnt == 3'd7);
  assign addr_hit  = (rx_byte[7:1] == SLAVE_ADDR);
  assign RD_ADDR   = ptr;
  assign I2C_SDAT  = sda_oe ? 1'b0 : 1'bz;

  // State register
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state; START/STOP win over everything else
  always_comb begin
    state_nxt = state;
    if (start_det)     state_nxt = ADDR;
    else if (stop_det) state_nxt = IDLE;
    else begin
      case (state)
        ADDR:      if (byte_done) state_nxt = addr_hit ? ACK : IGNORE;
        SUB,
        WDATA:     if (byte_done) state_nxt = ACK;
        ACK:       if (scl_fall && ack_drv) state_nxt = ack_ret;
        RDATA:     if (scl_fall && !rd_load && bit_cnt == 3'd7) state_nxt = MACK;
        MACK:      if (scl_rise) state_nxt = sda_s ? IGNORE : RDATA;
        default:   state_nxt = state;
      endcase
    end
  end

  // Output decode: only ACK and read-data slots may pull SDA low
  always_comb begin
    sda_oe = sda_low && ((state == ACK) || (state == RDATA));
  end

  // Shift register, bit counter, pointer, ACK sequencing and write strobe
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      bit_cnt <= '0;
      shreg   <= '0;
      ptr     <= '0;
      sda_low <= 1'b0;
      ack_drv <= 1'b0;
      ack_ret <= IDLE;
      rd_load <= 1'b0;
      BUSY    <= 1'b0;
      WR_EN   <= 1'b0;
      WR_ADDR <= '0;
      WR_DATA <= '0;
    end else begin
      WR_EN <= 1'b0;
      if (start_det || stop_det) begin
        // Any partial byte is dropped; pointer and write outputs untouched
        bit_cnt <= '0;
        sda_low <= 1'b0;
        ack_drv <= 1'b0;
        rd_load <= 1'b0;
        if (stop_det) BUSY <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shreg   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              BUSY    <= addr_hit;
              ack_ret <= rx_byte[RW_BIT] ? RDATA : SUB;
            end
          end
          SUB: if (scl_rise) begin
            shreg   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ptr     <= rx_byte;
              ack_ret <= WDATA;
            end
          end
          WDATA: if (scl_rise) begin
            shreg   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              WR_EN   <= 1'b1;
              WR_ADDR <= ptr;
              WR_DATA <= rx_byte;
              ptr     <= ptr + 8'd1;
              ack_ret <= WDATA;
            end
          end
          ACK: if (scl_fall) begin
            if (!ack_drv) begin
              sda_low <= 1'b1;
              ack_drv <= 1'b1;
            end else begin
              ack_drv <= 1'b0;
              sda_low <= 1'b0;
              // Read path: first byte goes out on the fall that ends the address ACK
              if (ack_ret == RDATA) begin
                shreg   <= RD_DATA[6:0];
                sda_low <= ~RD_DATA[7];
                bit_cnt <= '0;
              end
            end
          end
          RDATA: if (scl_fall) begin
            if (rd_load) begin
              shreg   <= RD_DATA[6:0];
              sda_low <= ~RD_DATA[7];
              rd_load <= 1'b0;
              bit_cnt <= '0;
            end else if (bit_cnt == 3'd7) begin
              sda_low <= 1'b0;
              ptr     <= ptr + 8'd1;
              bit_cnt <= '0;
            end else begin
              sda_low <= ~shreg[6];
              shreg   <= {shreg[5:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          MACK: if (scl_rise) begin
            if (sda_s) BUSY    <= 1'b0;
            else       rd_load <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Bench for i2c_slave_regif: bit-banged I2C master, register-file model, directed and random frames.
// Expected strobes, pointer and read data come from a byte-level model of the frame rules.
// The master never waits on the DUT; all timing is by CLOCK counts.
module tb_i2c_slave_regif;
  import i2c_slave_pkg::*;

  localparam int Q = 6;

  logic       CLOCK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  wire        sda;
  logic       wr_en, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  logic [7:0]  regmem    [256];
  logic [7:0]  model_mem [256];
  logic [7:0]  model_ptr;
  logic [15:0] strobes [$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          dut_low_cnt = 0;

  assign rd_data = regmem[rd_addr];

  i2c_slave_regif dut (
    .CLOCK    (CLOCK),
    .RESET_N  (RESET_N),
    .I2C_SCLK (scl),
    .I2C_SDAT (sda),
    .WR_EN    (wr_en),
    .WR_ADDR  (wr_addr),
    .WR_DATA  (wr_data),
    .RD_ADDR  (rd_addr),
    .RD_DATA  (rd_data),
    .BUSY     (busy)
  );

  always #5 CLOCK = ~CLOCK;

  // Register file behind the DUT, strobe log and DUT-pulls-low counter
  always @(negedge CLOCK) begin
    if (wr_en === 1'b1) begin
      strobes.push_back({wr_addr, wr_data});
      regmem[wr_addr] = wr_data;
    end
    if (sda === 1'b0 && !m_low) dut_low_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_q();
    repeat (Q) @(negedge CLOCK);
  endtask

  task automatic i2c_start();
    m_low = 1'b1; wait_q(); wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic i2c_rstart();
    m_low = 1'b0; wait_q();
    scl = 1'b1; wait_q();
    m_low = 1'b1; wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; wait_q();
    scl = 1'b1; wait_q();
    m_low = 1'b0; wait_q(); wait_q();
  endtask

  task automatic put_bit(input logic b);
    m_low = !b; wait_q();
    scl = 1'b1; wait_q(); wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic get_bit(output logic b);
    m_low = 1'b0; wait_q();
    scl = 1'b1; wait_q();
    b = sda;
    wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(b);
    ack = (b === 1'b0);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(nack);
  endtask

  task automatic test_reset();
    repeat (4) @(negedge CLOCK);
    n_tests++; if (wr_en !== 1'b0)    begin n_fail++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    n_tests++; if (wr_addr !== 8'h00) begin n_fail++; $display("FAIL reset_wr_addr got %h want 00", wr_addr); end
    n_tests++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data got %h want 00", wr_data); end
    n_tests++; if (rd_addr !== 8'h00) begin n_fail++; $display("FAIL reset_rd_addr got %h want 00", rd_addr); end
    n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (sda !== 1'b1)      begin n_fail++; $display("FAIL reset_sda got %b want 1", sda); end
    RESET_N = 1'b1;
    repeat (4) @(negedge CLOCK);
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    strobes.delete();
    i2c_start();
    send_byte(8'h34, a0);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy_mid got %b want 1", busy); end
    send_byte(8'h0E, a1);
    send_byte(8'h42, a2);
    i2c_stop();
    n_tests++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL write_acks got %b want 111", {a0, a1, a2}); end
    n_tests++; if (strobes.size() != 1) begin n_fail++; $display("FAIL write_strobe_count got %0d want 1", strobes.size()); end
    else begin
      n_tests++; if (strobes[0] !== 16'h0E42) begin n_fail++; $display("FAIL write_strobe got %h want 0e42", strobes[0]); end
    end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_end got %b want 0", busy); end
    n_tests++; if (rd_addr !== 8'h0F) begin n_fail++; $display("FAIL write_ptr got %h want 0f", rd_addr); end
    model_mem[8'h0E] = 8'h42;
    model_ptr = 8'h0F;
  endtask

  task automatic test_mismatch();
    logic a0, a1, a2;
    strobes.delete();
    dut_low_cnt = 0;
    i2c_start();
    send_byte(8'h36, a0);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mismatch_busy_mid got %b want 0", busy); end
    send_byte(8'h0E, a1);
    send_byte(8'h42, a2);
    i2c_stop();
    n_tests++; if (dut_low_cnt != 0) begin n_fail++; $display("FAIL mismatch_sda_low got %0d cycles want 0", dut_low_cnt); end
    n_tests++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL mismatch_acks got %b want 000", {a0, a1, a2}); end
    n_tests++; if (strobes.size() != 0) begin n_fail++; $display("FAIL mismatch_strobes got %0d want 0", strobes.size()); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mismatch_busy_end got %b want 0", busy); end
    n_tests++; if (rd_addr !== model_ptr) begin n_fail++; $display("FAIL mismatch_ptr got %h want %h", rd_addr, model_ptr); end
  endtask

  task automatic test_burst_wrap();
    logic a0, a1, a2, a3;
    strobes.delete();
    i2c_start();
    send_byte(8'h34, a0);
    send_byte(8'hFF, a1);
    send_byte(8'hAA, a2);
    send_byte(8'hBB, a3);
    i2c_stop();
    n_tests++; if ({a0, a1, a2, a3} !== 4'b1111) begin n_fail++; $display("FAIL burst_acks got %b want 1111", {a0, a1, a2, a3}); end
    n_tests++; if (strobes.size() != 2) begin n_fail++; $display("FAIL burst_count got %0d want 2", strobes.size()); end
    else begin
      n_tests++; if (strobes[0] !== 16'hFFAA) begin n_fail++; $display("FAIL burst_first got %h want ffaa", strobes[0]); end
      n_tests++; if (strobes[1] !== 16'h00BB) begin n_fail++; $display("FAIL burst_second got %h want 00bb", strobes[1]); end
    end
    n_tests++; if (rd_addr !== 8'h01) begin n_fail++; $display("FAIL burst_ptr got %h want 01", rd_addr); end
    model_mem[8'hFF] = 8'hAA;
    model_mem[8'h00] = 8'hBB;
    model_ptr = 8'h01;
  endtask

  task automatic test_read();
    logic a0, a1, a2;
    logic [7:0] d;
    strobes.delete();
    regmem[8'h05] = 8'h5A;
    model_mem[8'h05] = 8'h5A;
    i2c_start();
    send_byte(8'h34, a0);
    send_byte(8'h05, a1);
    i2c_rstart();
    send_byte(8'h35, a2);
    recv_byte(1'b1, d);
    i2c_stop();
    n_tests++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL read_acks got %b want 111", {a0, a1, a2}); end
    n_tests++; if (d !== 8'h5A) begin n_fail++; $display("FAIL read_data got %h want 5a", d); end
    n_tests++; if (rd_addr !== 8'h06) begin n_fail++; $display("FAIL read_ptr got %h want 06", rd_addr); end
    n_tests++; if (strobes.size() != 0) begin n_fail++; $display("FAIL read_strobes got %0d want 0", strobes.size()); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL read_busy_end got %b want 0", busy); end
    model_ptr = 8'h06;
  endtask

  task automatic test_partial_stop();
    logic a0, a1;
    strobes.delete();
    i2c_start();
    send_byte(8'h34, a0);
    send_byte(8'h10, a1);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
    i2c_stop();
    n_tests++; if (strobes.size() != 0) begin n_fail++; $display("FAIL partial_strobes got %0d want 0", strobes.size()); end
    n_tests++; if (rd_addr !== 8'h10) begin n_fail++; $display("FAIL partial_ptr got %h want 10", rd_addr); end
    n_tests++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL partial_state got %0d want %0d", dut.state, IDLE); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL partial_busy got %b want 0", busy); end
    model_ptr = 8'h10;
  endtask

  task automatic test_reset_mid_ack();
    logic a0, a1, a2;
    logic [7:0] adr;
    adr = 8'h34;
    strobes.delete();
    i2c_start();
    for (int i = 7; i >= 0; i--) put_bit(adr[i]);
    m_low = 1'b0;
    @(negedge CLOCK);
    n_tests++; if (sda !== 1'b0) begin n_fail++; $display("FAIL rst_ack_driven got %b want 0", sda); end
    RESET_N = 1'b0;
    #1;
    n_tests++; if (sda !== 1'b1)      begin n_fail++; $display("FAIL rst_sda_release got %b want 1", sda); end
    n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_tests++; if (rd_addr !== 8'h00) begin n_fail++; $display("FAIL rst_ptr got %h want 00", rd_addr); end
    n_tests++; if (wr_addr !== 8'h00) begin n_fail++; $display("FAIL rst_wr_addr got %h want 00", wr_addr); end
    n_tests++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL rst_wr_data got %h want 00", wr_data); end
    repeat (3) @(negedge CLOCK);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLOCK);
    i2c_stop();
    n_tests++; if (strobes.size() != 0) begin n_fail++; $display("FAIL rst_no_strobe got %0d want 0", strobes.size()); end
    model_ptr = 8'h00;
    i2c_start();
    send_byte(8'h34, a0);
    send_byte(8'h21, a1);
    send_byte(8'h77, a2);
    i2c_stop();
    n_tests++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL rst_next_acks got %b want 111", {a0, a1, a2}); end
    n_tests++; if (strobes.size() != 1) begin n_fail++; $display("FAIL rst_next_count got %0d want 1", strobes.size()); end
    else begin
      n_tests++; if (strobes[0] !== 16'h2177) begin n_fail++; $display("FAIL rst_next_strobe got %h want 2177", strobes[0]); end
    end
    model_mem[8'h21] = 8'h77;
    model_ptr = 8'h22;
  endtask

  task automatic test_random();
    logic        ack;
    int          kind, n, nacks;
    logic [7:0]  sub, d;
    logic [15:0] exp_q [$];
    logic [7:0]  got_q [$];
    logic [7:0]  want_q [$];
    for (int it = 0; it < 16; it++) begin
      kind = $urandom_range(0, 2);
      n    = $urandom_range(1, 4);
      sub  = 8'($urandom);
      nacks = 0;
      strobes.delete(); exp_q.delete(); got_q.delete(); want_q.delete();
      i2c_start();
      if (kind == 0) begin
        send_byte(8'h34, ack); if (!ack) nacks++;
        send_byte(sub, ack);   if (!ack) nacks++;
        model_ptr = sub;
        for (int k = 0; k < n; k++) begin
          d = 8'($urandom);
          send_byte(d, ack); if (!ack) nacks++;
          exp_q.push_back({model_ptr, d});
          model_mem[model_ptr] = d;
          model_ptr = model_ptr + 8'd1;
        end
      end else begin
        if (kind == 1) begin
          send_byte(8'h34, ack); if (!ack) nacks++;
          send_byte(sub, ack);   if (!ack) nacks++;
          model_ptr = sub;
          i2c_rstart();
        end
        send_byte(8'h35, ack); if (!ack) nacks++;
        for (int k = 0; k < n; k++) begin
          recv_byte(k == n - 1, d);
          got_q.push_back(d);
          want_q.push_back(model_mem[model_ptr]);
          model_ptr = model_ptr + 8'd1;
        end
      end
      i2c_stop();
      n_tests++; if (nacks != 0) begin n_fail++; $display("FAIL rand%0d_acks got %0d nacks want 0", it, nacks); end
      n_tests++; if (strobes != exp_q) begin n_fail++; $display("FAIL rand%0d_strobes got %p want %p", it, strobes, exp_q); end
      n_tests++; if (got_q != want_q) begin n_fail++; $display("FAIL rand%0d_rdata got %p want %p", it, got_q, want_q); end
      n_tests++; if (rd_addr !== model_ptr) begin n_fail++; $display("FAIL rand%0d_ptr got %h want %h", it, rd_addr, model_ptr); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      regmem[i]    = 8'($urandom);
      model_mem[i] = regmem[i];
    end
    model_ptr = 8'h00;
    test_reset();
    test_write();
    test_mismatch();
    test_burst_wrap();
    test_read();
    test_partial_stop();
    test_reset_mid_ack();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regif.md
Name: i2c_slave_regif

Overview:
- I2C target (responder) that terminates the 3-byte codec write frame [SLAVE_ADDR+W, SUB_ADDR, DATA] and converts it into a single-cycle register write strobe on CLOCK.
- Also supports burst writes and register reads through a repeated START.
- Used as a bench model and on-chip responder for the audio configuration bus.
- SCL/SDA are oversampled by CLOCK; the block never stretches SCL.

Parameters:
- SLAVE_ADDR, 7'h1A, 7-bit target address (0x34 write / 0x35 read).
- SYNC_STAGES, 2, synchronizer depth on SCL and SDA inputs (≥2).

Ports:
- CLOCK  in  1  system clock; must be ≥10× SCL frequency.
- RESET_N  in  1  asynchronous, active-low reset.
- I2C_SCLK  in  1  bus clock from master.
- I2C_SDAT  inout  1  bus data, open-drain: driven 0 or released to z, never driven 1.
- WR_EN  out  1  one-CLOCK write strobe.
- WR_ADDR  out  8  register address for write.
- WR_DATA  out  8  register data for write.
- RD_ADDR  out  8  current register pointer, for combinational read.
- RD_DATA  in  8  register data at RD_ADDR; sampled when a read byte is loaded.
- BUSY  out  1  high from addressed START to STOP/NACK/mismatch.

Behaviour:
- Reset (async): SDA released, WR_EN=0, WR_ADDR=0, WR_DATA=0, RD_ADDR (pointer)=0, BUSY=0, state IDLE, bit count 0.
- Reset asserted mid-transfer releases SDA in the same instant and aborts. No WR_EN is issued.
- Inputs pass SYNC_STAGES flops, then one edge-detect register.
  - SCL rise/fall events lag the pins by SYNC_STAGES+1 CLOCKs.
- START: synced SDA falls while SCL high. STOP: synced SDA rises while SCL high.
  - START/STOP override every state.
  - START (including repeated) → ADDR with bit count cleared.
  - STOP → IDLE with SDA released.
- Data bits are sampled on the SCL rise event, MSB first. SDA is changed only on the SCL fall event.
- States and transitions:
  - IDLE: SDA released; wait for START.
  - ADDR: shift 8 bits. On the 8th bit:
    - if bits[7:1]==SLAVE_ADDR → ACK, set BUSY; R/W bit selects write path (0) or read path (1).
    - else → IGNORE.
  - IGNORE: never drive SDA; wait for START/STOP.
  - ACK (generic): on the SCL fall after the 8th bit, drive SDA=0; on the next SCL fall, release SDA and go to the next state.
  - SUB: shift 8 bits; load the pointer on the 8th bit; ACK; → WDATA.
  - WDATA: shift 8 bits. On the 8th sample:
    - WR_ADDR←pointer, WR_DATA←byte, WR_EN=1 for exactly one CLOCK.
    - pointer increments; 8'hFF wraps to 8'h00.
    - ACK; → WDATA (burst).
  - RDATA: on the SCL fall ending the address ACK, load RD_DATA into the shift register and drive its MSB. Shift out on each SCL fall (driving 1 means release). After 8 bits, release SDA and pointer increments → MACK.
  - MACK: sample SDA on SCL rise.
    - 0 (ACK) → RDATA, loading the next byte on the following fall.
    - 1 (NACK) → IGNORE; BUSY=0.
- STOP within a partial byte discards it: no WR_EN and no pointer change.
- BUSY falls on STOP, NACK, mismatch or reset.
- WR_ADDR/WR_DATA hold their values between strobes.

Decomposition:
- Package i2c_slave_pkg holds:
  - state enum (IDLE, ADDR, IGNORE, ACK, SUB, WDATA, RDATA, MACK);
  - default address constant 7'h1A;
  - R/W bit index.
- Sub-module i2c_line_sync: synchronizer plus scl_rise/scl_fall/start/stop pulse generation. Instantiated once.

Test Plan:
- Write frame 0x34,0x0E,0x42,STOP → ACK low in all 3 ack slots; one WR_EN with WR_ADDR=0x0E, WR_DATA=0x42; BUSY 0 after STOP.
- Frame to 0x36,0x0E,0x42 → SDA never driven low by DUT; no WR_EN; BUSY stays 0.
- Burst 0x34,0xFF,0xAA,0xBB,STOP → two strobes, (0xFF,0xAA) then (0x00,0xBB); pointer ends at 0x01.
- Read: 0x34,0x05, repeated START, 0x35, RD_DATA model returns 0x5A at RD_ADDR 0x05, master NACK, STOP → master receives 0x5A; pointer=0x06; no WR_EN.
- STOP after 4 bits of a data byte → no WR_EN, pointer unchanged, state IDLE.
- RESET_N pulsed low while DUT drives an ACK → SDA released immediately; all outputs at reset values; the next valid frame is accepted normally.
